// File: rtl/gate_vector_checker_pkg.sv
// Shared types and constants for the gate-library response checker.
// Bit positions of the six gate outputs, FSM encodings and the popcount helper.
package gate_vector_checker_pkg;

  localparam int unsigned GATE_N = 6;
  localparam int unsigned VEC_N  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned POP_W  = 3;

  localparam int unsigned GT_AND  = 0;
  localparam int unsigned GT_OR   = 1;
  localparam int unsigned GT_XOR  = 2;
  localparam int unsigned GT_NOT  = 3;
  localparam int unsigned GT_NAND = 4;
  localparam int unsigned GT_NOR  = 5;

  typedef logic [GATE_N-1:0] gate_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // Sweep result fields that travel together to the reporting ports.
  typedef struct packed {
    logic                 pass;
    logic [IDX_W-1:0]     first_fail_vec;
    gate_vec_t            fail_mask;
  } sweep_result_t;

  function automatic logic [POP_W-1:0] popcount6(input gate_vec_t v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < GATE_N; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// Stimulus/response and result bundle between the checker and the gates under test.
// The slave side is the checker; the master side drives start and the gate outputs.
interface gate_vector_checker_if
  import gate_vector_checker_pkg::*;
#(
  parameter int unsigned ERR_W = 8
);

  logic             start;
  logic             a;
  logic             b;
  gate_vec_t        dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] first_fail_vec;
  gate_vec_t        fail_mask;

  modport master (
    output start,
    output dut_out,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_vec,
    input  fail_mask
  );

  modport slave (
    input  start,
    input  dut_out,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_vec,
    output fail_mask
  );

endinterface

// File: rtl/gate_golden.sv
// Golden truth table for the six library gates, indexed by the shared bit positions.
module gate_golden
  import gate_vector_checker_pkg::*;
(
  input  logic      a,
  input  logic      b,
  output gate_vec_t gold_c
);

  always_comb begin
    gold_c          = '0;
    gold_c[GT_AND]  = a & b;
    gold_c[GT_OR]   = a | b;
    gold_c[GT_XOR]  = a ^ b;
    gold_c[GT_NOT]  = ~a;
    gold_c[GT_NAND] = ~(a & b);
    gold_c[GT_NOR]  = ~(a | b);
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps the four a/b vectors through the gate library, compares the sampled
// outputs against the golden table and accumulates a saturating error report.
module gate_vector_checker
  import gate_vector_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ERR_W         = 8
)(
  input  logic               clk,
  input  logic               rst,
  gate_vector_checker_if.slave bus
);

  localparam int unsigned CNT_W       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam int unsigned SUM_W       = ERR_W + 3;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ERR_W-1:0] err_q, err_d;
  sweep_result_t    res_q, res_d;

  gate_vec_t        gold_c;
  gate_vec_t        mism_c;
  logic [POP_W-1:0] pop_c;
  logic [SUM_W-1:0] sum_c;
  logic [ERR_W-1:0] err_sat_c;

  // Golden is indexed by the vector number, which maps to (a,b) = (idx[0], idx[1]).
  gate_golden u_golden (
    .a      (idx_q[0]),
    .b      (idx_q[1]),
    .gold_c (gold_c)
  );

  assign mism_c = bus.dut_out ^ gold_c;
  assign pop_c  = popcount6(mism_c);
  assign sum_c  = SUM_W'(err_q) + SUM_W'(pop_c);

  // Widened sum clamps at all-ones instead of wrapping.
  always_comb begin
    err_sat_c = ERR_W'(sum_c);
    if (sum_c > SUM_W'({ERR_W{1'b1}})) begin
      err_sat_c = '1;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    res_d   = res_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_APPLY;
          idx_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = '0;
          res_d   = '0;
        end
      end

      ST_APPLY: begin
        a_d   = idx_q[0];
        b_d   = idx_q[1];
        cnt_d = '0;
        if (SETTLE_CYCLES == 0) begin
          state_d = ST_SAMPLE;
        end else begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_LAST)) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SAMPLE: begin
        err_d           = err_sat_c;
        res_d.fail_mask = res_q.fail_mask | mism_c;
        // An empty mask means no vector of this sweep has failed yet.
        if ((mism_c != '0) && (res_q.fail_mask == '0)) begin
          res_d.first_fail_vec = idx_q;
        end
        if (idx_q == IDX_W'(VEC_N - 1)) begin
          state_d    = ST_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          a_d        = 1'b0;
          b_d        = 1'b0;
          res_d.pass = (err_d == '0);
        end else begin
          state_d = ST_APPLY;
          idx_d   = idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = res_q.pass;
  assign bus.err_count      = err_q;
  assign bus.first_fail_vec = res_q.first_fail_vec;
  assign bus.fail_mask      = res_q.fail_mask;

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: three instances cover the default,
// narrow-counter and zero-settle configurations against a NAND-built gate model.
module tb_gate_vector_checker;
  import gate_vector_checker_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [1:0] mode2, mode_e2, mode0;

  gate_vector_checker_if #(.ERR_W(8)) bus2   ();
  gate_vector_checker_if #(.ERR_W(2)) bus_e2 ();
  gate_vector_checker_if #(.ERR_W(8)) bus0   ();

  gate_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(8)) u_dut2   (.clk(clk), .rst(rst), .bus(bus2));
  gate_vector_checker #(.SETTLE_CYCLES(2), .ERR_W(2)) u_dut_e2 (.clk(clk), .rst(rst), .bus(bus_e2));
  gate_vector_checker #(.SETTLE_CYCLES(0), .ERR_W(8)) u_dut0   (.clk(clk), .rst(rst), .bus(bus0));

  // Gate library built only from 2-input NANDs.
  function automatic gate_vec_t gate_lib(input logic a, input logic b);
    logic n_ab, na, nb, t1, t2;
    gate_vec_t v;
    n_ab = ~(a & b);
    na   = ~(a & a);
    nb   = ~(b & b);
    t1   = ~(a & n_ab);
    t2   = ~(b & n_ab);
    v[0] = ~(n_ab & n_ab);
    v[1] = ~(na & nb);
    v[2] = ~(t1 & t2);
    v[3] = na;
    v[4] = n_ab;
    v[5] = ~(v[1] & v[1]);
    return v;
  endfunction

  // 0: healthy, 1: xor stuck-at-0, 2: every output inverted.
  function automatic gate_vec_t apply_fault(input gate_vec_t v, input logic [1:0] mode);
    case (mode)
      2'd1:    return v & 6'b111011;
      2'd2:    return ~v;
      default: return v;
    endcase
  endfunction

  assign bus2.dut_out   = apply_fault(gate_lib(bus2.a, bus2.b), mode2);
  assign bus_e2.dut_out = apply_fault(gate_lib(bus_e2.a, bus_e2.b), mode_e2);
  assign bus0.dut_out   = apply_fault(gate_lib(bus0.a, bus0.b), mode0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       bus2.start = v;
      1:       bus_e2.start = v;
      default: bus0.start = v;
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0:       return bus2.done;
      1:       return bus_e2.done;
      default: return bus0.done;
    endcase
  endfunction

  // Leaves the bench at the falling edge right after the start edge.
  task automatic pulse_start(input int which);
    @(negedge clk);
    set_start(which, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_start(which, 1'b0);
  endtask

  // Counts rising edges after the start edge until done is seen (bounded).
  task automatic wait_done(input int which, output int cyc);
    cyc = 0;
    while (!get_done(which) && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_sweep(input int which, output int cyc);
    pulse_start(which);
    wait_done(which, cyc);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if ({bus2.a, bus2.b, bus2.busy, bus2.done, bus2.pass} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000", {bus2.a, bus2.b, bus2.busy, bus2.done, bus2.pass}); end
    n_cmp++; if (bus2.err_count !== 8'd0) begin
      n_fail++; $display("FAIL reset_err got=%0d exp=0", bus2.err_count); end
    n_cmp++; if ({bus2.first_fail_vec, bus2.fail_mask} !== 8'd0) begin
      n_fail++; $display("FAIL reset_ffv_mask got=%h exp=00", {bus2.first_fail_vec, bus2.fail_mask}); end
    n_cmp++; if ({bus0.busy, bus0.done, bus0.err_count, bus_e2.err_count} !== 12'd0) begin
      n_fail++; $display("FAIL reset_others got=%h exp=000", {bus0.busy, bus0.done, bus0.err_count, bus_e2.err_count}); end
  endtask

  task automatic test_clean_sweep();
    int cyc;
    int idx;
    mode2 = 2'd0;
    pulse_start(0);
    n_cmp++; if (bus2.busy !== 1'b1) begin
      n_fail++; $display("FAIL s1_busy got=%b exp=1", bus2.busy); end
    cyc = 0;
    while (!bus2.done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc % 4 == 3) begin
        idx = cyc / 4;
        n_cmp++; if ({bus2.a, bus2.b} !== {idx[0], idx[1]}) begin
          n_fail++; $display("FAIL s1_ab_vec%0d got=%b exp=%b", idx, {bus2.a, bus2.b}, {idx[0], idx[1]}); end
      end
    end
    n_cmp++; if (cyc !== 16) begin
      n_fail++; $display("FAIL s1_latency got=%0d exp=16", cyc); end
    n_cmp++; if ({bus2.pass, bus2.busy, bus2.a, bus2.b} !== 4'b1000) begin
      n_fail++; $display("FAIL s1_flags got=%b exp=1000", {bus2.pass, bus2.busy, bus2.a, bus2.b}); end
    n_cmp++; if ({bus2.err_count, bus2.fail_mask} !== 14'd0) begin
      n_fail++; $display("FAIL s1_errs got=%h exp=0000", {bus2.err_count, bus2.fail_mask}); end
  endtask

  task automatic test_xor_stuck();
    int cyc;
    mode2 = 2'd1;
    run_sweep(0, cyc);
    n_cmp++; if (cyc !== 16) begin
      n_fail++; $display("FAIL s2_latency got=%0d exp=16", cyc); end
    n_cmp++; if (bus2.err_count !== 8'd2) begin
      n_fail++; $display("FAIL s2_err got=%0d exp=2", bus2.err_count); end
    n_cmp++; if (bus2.fail_mask !== 6'b000100) begin
      n_fail++; $display("FAIL s2_mask got=%b exp=000100", bus2.fail_mask); end
    n_cmp++; if ({bus2.first_fail_vec, bus2.pass} !== 3'b010) begin
      n_fail++; $display("FAIL s2_ffv_pass got=%b exp=010", {bus2.first_fail_vec, bus2.pass}); end
  endtask

  task automatic test_saturation();
    int cyc;
    mode_e2 = 2'd2;
    run_sweep(1, cyc);
    n_cmp++; if (cyc !== 16) begin
      n_fail++; $display("FAIL s3_latency got=%0d exp=16", cyc); end
    n_cmp++; if (bus_e2.err_count !== 2'd3) begin
      n_fail++; $display("FAIL s3_err_sat got=%0d exp=3", bus_e2.err_count); end
    n_cmp++; if (bus_e2.fail_mask !== 6'h3F) begin
      n_fail++; $display("FAIL s3_mask got=%h exp=3f", bus_e2.fail_mask); end
    n_cmp++; if ({bus_e2.first_fail_vec, bus_e2.pass} !== 3'b000) begin
      n_fail++; $display("FAIL s3_ffv_pass got=%b exp=000", {bus_e2.first_fail_vec, bus_e2.pass}); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    mode2 = 2'd0;
    pulse_start(0);
    n_cmp++; if ({bus2.err_count, bus2.fail_mask, bus2.first_fail_vec} !== 16'd0) begin
      n_fail++; $display("FAIL s4_clear got=%h exp=0000", {bus2.err_count, bus2.fail_mask, bus2.first_fail_vec}); end
    n_cmp++; if ({bus2.done, bus2.busy} !== 2'b01) begin
      n_fail++; $display("FAIL s4_done_busy got=%b exp=01", {bus2.done, bus2.busy}); end
    cyc = 0;
    while (!bus2.done && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 9)  bus2.start = 1'b1;
      if (cyc == 10) bus2.start = 1'b0;
    end
    bus2.start = 1'b0;
    n_cmp++; if (cyc !== 16) begin
      n_fail++; $display("FAIL s4_latency got=%0d exp=16", cyc); end
    n_cmp++; if ({bus2.pass, bus2.err_count, bus2.fail_mask} !== {1'b1, 14'd0}) begin
      n_fail++; $display("FAIL s4_result got=%h exp=4000", {bus2.pass, bus2.err_count, bus2.fail_mask}); end
  endtask

  task automatic test_rst_abort();
    int cyc;
    mode2 = 2'd2;
    pulse_start(0);
    cyc = 0;
    while (cyc < 7) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 4) begin
        n_cmp++; if (bus2.err_count !== 8'd6) begin
          n_fail++; $display("FAIL s5_partial_err got=%0d exp=6", bus2.err_count); end
      end
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({bus2.a, bus2.b, bus2.busy, bus2.done, bus2.pass} !== 5'b0) begin
      n_fail++; $display("FAIL s5_rst_ctrl got=%b exp=00000", {bus2.a, bus2.b, bus2.busy, bus2.done, bus2.pass}); end
    n_cmp++; if ({bus2.err_count, bus2.first_fail_vec, bus2.fail_mask} !== 16'd0) begin
      n_fail++; $display("FAIL s5_rst_res got=%h exp=0000", {bus2.err_count, bus2.first_fail_vec, bus2.fail_mask}); end
    mode2 = 2'd0;
    run_sweep(0, cyc);
    n_cmp++; if (cyc !== 16) begin
      n_fail++; $display("FAIL s5_resweep_latency got=%0d exp=16", cyc); end
    n_cmp++; if ({bus2.pass, bus2.err_count, bus2.fail_mask} !== {1'b1, 14'd0}) begin
      n_fail++; $display("FAIL s5_resweep_result got=%h exp=4000", {bus2.pass, bus2.err_count, bus2.fail_mask}); end
  endtask

  task automatic test_zero_settle();
    int cyc;
    mode0 = 2'd1;
    run_sweep(2, cyc);
    n_cmp++; if (cyc !== 8) begin
      n_fail++; $display("FAIL s6_latency1 got=%0d exp=8", cyc); end
    n_cmp++; if ({bus0.err_count, bus0.fail_mask, bus0.first_fail_vec} !== {8'd2, 6'b000100, 2'd1}) begin
      n_fail++; $display("FAIL s6_stale got=%h exp=0211", {bus0.err_count, bus0.fail_mask, bus0.first_fail_vec}); end
    mode0 = 2'd0;
    pulse_start(2);
    n_cmp++; if ({bus0.err_count, bus0.fail_mask, bus0.first_fail_vec} !== 16'd0) begin
      n_fail++; $display("FAIL s6_clear got=%h exp=0000", {bus0.err_count, bus0.fail_mask, bus0.first_fail_vec}); end
    n_cmp++; if ({bus0.pass, bus0.done, bus0.busy} !== 3'b001) begin
      n_fail++; $display("FAIL s6_flags_start got=%b exp=001", {bus0.pass, bus0.done, bus0.busy}); end
    wait_done(2, cyc);
    n_cmp++; if (cyc !== 8) begin
      n_fail++; $display("FAIL s6_latency2 got=%0d exp=8", cyc); end
    n_cmp++; if ({bus0.pass, bus0.err_count} !== 9'h100) begin
      n_fail++; $display("FAIL s6_result got=%h exp=100", {bus0.pass, bus0.err_count}); end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    mode2        = 2'd0;
    mode_e2      = 2'd0;
    mode0        = 2'd0;
    bus2.start   = 1'b0;
    bus_e2.start = 1'b0;
    bus0.start   = 1'b0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_clean_sweep();
    test_xor_stuck();
    test_saturation();
    test_start_ignored();
    test_rst_abort();
    test_zero_settle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
